// File: rtl/sram_arbiter.sv
// Arbitrates the BaseRAM/ExtRAM SRAM pair between instruction fetch and the MEM stage,
// sequencing each access as a multi-cycle SRAM cycle with registered pin controls.
module sram_arbiter #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 1,
  parameter int unsigned BANK_BIT  = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        mem_byte,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  input  logic [31:0] base_ram_data_i,
  output logic [31:0] base_ram_data_o,
  output logic        base_ram_data_oe,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  input  logic [31:0] ext_ram_data_i,
  output logic [31:0] ext_ram_data_o,
  output logic        ext_ram_data_oe,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

  localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        last_mem;
  logic        lat_mem;
  logic        lat_byte;
  logic        lat_bank;
  logic [1:0]  lat_lane;

  logic        g_mem;
  logic        g_any;
  logic        g_we;
  logic        g_byte;
  logic        g_bank;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  g_be_n;
  logic [31:0] rd_raw;
  logic [7:0]  rd_byte;
  logic [31:0] rd_word;

  // Only the bits the SRAM map needs are consumed from the address/data buses.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{if_addr, mem_addr, mem_wdata};

  always_comb begin
    // On a tie, the port not served last wins.
    g_mem   = mem_req && (!if_req || !last_mem);
    g_any   = g_mem || if_req;
    g_addr  = g_mem ? mem_addr : if_addr;
    g_we    = g_mem && mem_we;
    g_byte  = g_mem && mem_byte;
    g_bank  = g_addr[BANK_BIT];
    g_be_n  = (g_we && g_byte) ? ~(4'b0001 << g_addr[1:0]) : 4'b0000;
    g_wdata = g_byte ? {4{mem_wdata[7:0]}} : mem_wdata;
    rd_raw  = lat_bank ? ext_ram_data_i : base_ram_data_i;
    rd_byte = rd_raw[{lat_lane, 3'b000} +: 8];
    rd_word = lat_byte ? {{24{rd_byte[7]}}, rd_byte} : rd_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      last_mem         <= 1'b0;
      lat_mem          <= 1'b0;
      lat_byte         <= 1'b0;
      lat_bank         <= 1'b0;
      lat_lane         <= '0;
      if_ack           <= 1'b0;
      mem_ack          <= 1'b0;
      if_rdata         <= '0;
      mem_rdata        <= '0;
      base_ram_data_o  <= '0;
      base_ram_data_oe <= 1'b0;
      base_ram_addr    <= '0;
      base_ram_be_n    <= '1;
      base_ram_ce_n    <= 1'b1;
      base_ram_oe_n    <= 1'b1;
      base_ram_we_n    <= 1'b1;
      ext_ram_data_o   <= '0;
      ext_ram_data_oe  <= 1'b0;
      ext_ram_addr     <= '0;
      ext_ram_be_n     <= '1;
      ext_ram_ce_n     <= 1'b1;
      ext_ram_oe_n     <= 1'b1;
      ext_ram_we_n     <= 1'b1;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (g_any) begin
            last_mem <= g_mem;
            lat_mem  <= g_mem;
            lat_byte <= g_byte;
            lat_lane <= g_addr[1:0];
            lat_bank <= g_bank;
            cnt      <= '0;
            if (g_bank) begin
              ext_ram_addr    <= g_addr[21:2];
              ext_ram_be_n    <= g_be_n;
              ext_ram_ce_n    <= 1'b0;
              ext_ram_oe_n    <= g_we;
              ext_ram_data_oe <= g_we;
              if (g_we) ext_ram_data_o <= g_wdata;
            end else begin
              base_ram_addr    <= g_addr[21:2];
              base_ram_be_n    <= g_be_n;
              base_ram_ce_n    <= 1'b0;
              base_ram_oe_n    <= g_we;
              base_ram_data_oe <= g_we;
              if (g_we) base_ram_data_o <= g_wdata;
            end
            state <= g_we ? WR_SETUP : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == RD_LAST) begin
            state         <= DONE;
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            ext_ram_ce_n  <= 1'b1;
            ext_ram_oe_n  <= 1'b1;
            if (lat_mem) begin
              mem_rdata <= rd_word;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= rd_word;
              if_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_SETUP: begin
          state <= WR_PULSE;
          cnt   <= '0;
          if (lat_bank) ext_ram_we_n <= 1'b0;
          else          base_ram_we_n <= 1'b0;
        end
        WR_PULSE: begin
          if (cnt == WR_LAST) begin
            state         <= WR_HOLD;
            base_ram_we_n <= 1'b1;
            ext_ram_we_n  <= 1'b1;
            mem_ack       <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_HOLD: begin
          state            <= IDLE;
          base_ram_ce_n    <= 1'b1;
          ext_ram_ce_n     <= 1'b1;
          base_ram_data_oe <= 1'b0;
          ext_ram_data_oe  <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM device model on the pins plus an
// independent memory reference that predicts read data, lane enables and timing.
module tb_sram_arbiter;

  localparam int RD = 2;
  localparam int WR = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_req, mem_we, mem_byte;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        if_ack, mem_ack;
  logic [31:0] if_rdata, mem_rdata;
  logic [31:0] base_ram_data_i, base_ram_data_o, ext_ram_data_i, ext_ram_data_o;
  logic        base_ram_data_oe, ext_ram_data_oe;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

  logic        b_if_req, b_mem_req, b_mem_we, b_mem_byte;
  logic [31:0] b_if_addr, b_mem_addr, b_mem_wdata;
  logic        b_if_ack, b_mem_ack;
  logic [31:0] b_if_rdata, b_mem_rdata;
  logic [31:0] b_base_data_o, b_ext_data_o;
  logic        b_base_data_oe, b_ext_data_oe;
  logic [19:0] b_base_addr, b_ext_addr;
  logic [3:0]  b_base_be_n, b_ext_be_n;
  logic        b_base_ce_n, b_base_oe_n, b_base_we_n;
  logic        b_ext_ce_n, b_ext_oe_n, b_ext_we_n;

  logic [31:0] dev_base [256];
  logic [31:0] dev_ext  [256];
  logic [31:0] ref_base [256];
  logic [31:0] ref_ext  [256];
  logic        dev_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR), .BANK_BIT(22)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .base_ram_data_i(base_ram_data_i), .base_ram_data_o(base_ram_data_o),
    .base_ram_data_oe(base_ram_data_oe), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data_i(ext_ram_data_i), .ext_ram_data_o(ext_ram_data_o),
    .ext_ram_data_oe(ext_ram_data_oe), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
  );

  sram_arbiter #(.RD_CYCLES(3), .WR_CYCLES(2), .BANK_BIT(22)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_byte(b_mem_byte), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .base_ram_data_i(32'hCAFE_F00D), .base_ram_data_o(b_base_data_o),
    .base_ram_data_oe(b_base_data_oe), .base_ram_addr(b_base_addr),
    .base_ram_be_n(b_base_be_n), .base_ram_ce_n(b_base_ce_n),
    .base_ram_oe_n(b_base_oe_n), .base_ram_we_n(b_base_we_n),
    .ext_ram_data_i(32'h0000_0000), .ext_ram_data_o(b_ext_data_o),
    .ext_ram_data_oe(b_ext_data_oe), .ext_ram_addr(b_ext_addr),
    .ext_ram_be_n(b_ext_be_n), .ext_ram_ce_n(b_ext_ce_n),
    .ext_ram_oe_n(b_ext_oe_n), .ext_ram_we_n(b_ext_we_n)
  );

  function automatic logic [31:0] pat(input bit bank, input int idx);
    logic [7:0] b;
    b = 8'(idx);
    return {(bank ? 8'hE0 : 8'hB0) ^ b, b, 8'h5A ^ b, 8'h3C + b};
  endfunction

  // Asynchronous-read SRAM pair; writes land on clock edges while we_n is low.
  assign base_ram_data_i = (!base_ram_ce_n && !base_ram_oe_n) ? dev_base[base_ram_addr[7:0]] : 32'hDEAD_BEEF;
  assign ext_ram_data_i  = (!ext_ram_ce_n && !ext_ram_oe_n) ? dev_ext[ext_ram_addr[7:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!dev_ready) begin
      for (int i = 0; i < 256; i++) begin
        dev_base[i] <= pat(1'b0, i);
        dev_ext[i]  <= pat(1'b1, i);
      end
      dev_ready <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[i])
          dev_base[base_ram_addr[7:0]][8*i +: 8] <= base_ram_data_o[8*i +: 8];
        if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[i])
          dev_ext[ext_ram_addr[7:0]][8*i +: 8] <= ext_ram_data_o[8*i +: 8];
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_access(input bit pm, input bit we, input bit byt,
                           input logic [31:0] addr, input logic [31:0] wdata, input string nm);
    bit          bank, got, other_bad;
    logic [19:0] exp_addr, cap_addr;
    logic [3:0]  exp_be, cap_be;
    logic [31:0] exp_do, exp_rd, w, cap_do, rd;
    logic [7:0]  idx, lb;
    logic        cap_ce, cap_doe;
    int          n, exp_n, oe_lo, we_lo;
    if (!pm) begin we = 1'b0; byt = 1'b0; end
    bank     = addr[22];
    idx      = addr[9:2];
    exp_addr = addr[21:2];
    exp_be   = (we && byt) ? ~(4'b0001 << addr[1:0]) : 4'b0000;
    exp_do   = byt ? {4{wdata[7:0]}} : wdata;
    w        = bank ? ref_ext[idx] : ref_base[idx];
    lb       = w[8*addr[1:0] +: 8];
    exp_rd   = byt ? {{24{lb[7]}}, lb} : w;
    exp_n    = we ? WR + 2 : RD + 1;
    cap_ce = 1'b1; cap_addr = '0; cap_be = '1; cap_do = '0; cap_doe = 1'b0;
    @(negedge clk);
    if (pm) begin
      mem_req = 1'b1; mem_we = we; mem_byte = byt; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    n = 0; got = 0; oe_lo = 0; we_lo = 0; other_bad = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bank) begin
        if (!ext_ram_oe_n) oe_lo++;
        if (!ext_ram_we_n) we_lo++;
        if (!base_ram_ce_n || base_ram_data_oe) other_bad = 1;
      end else begin
        if (!base_ram_oe_n) oe_lo++;
        if (!base_ram_we_n) we_lo++;
        if (!ext_ram_ce_n || ext_ram_data_oe) other_bad = 1;
      end
      if (n == 1) begin
        cap_ce   = bank ? ext_ram_ce_n     : base_ram_ce_n;
        cap_addr = bank ? ext_ram_addr     : base_ram_addr;
        cap_be   = bank ? ext_ram_be_n     : base_ram_be_n;
        cap_do   = bank ? ext_ram_data_o   : base_ram_data_o;
        cap_doe  = bank ? ext_ram_data_oe  : base_ram_data_oe;
      end
      if (pm ? if_ack : mem_ack) other_bad = 1;
      got = pm ? mem_ack : if_ack;
    end
    rd = pm ? mem_rdata : if_rdata;
    if_req = 1'b0; mem_req = 1'b0;
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (!exp_be[i]) begin
          if (bank) ref_ext[idx][8*i +: 8] = exp_do[8*i +: 8];
          else      ref_base[idx][8*i +: 8] = exp_do[8*i +: 8];
        end
    end
    n_cmp++; if (!got || n != exp_n) begin n_bad++; $display("FAIL %s latency: got %0d (ack=%0d) want %0d", nm, n, got, exp_n); end
    n_cmp++; if (cap_ce !== 1'b0) begin n_bad++; $display("FAIL %s ce_n: got %b want 0", nm, cap_ce); end
    n_cmp++; if (cap_addr !== exp_addr) begin n_bad++; $display("FAIL %s ram_addr: got %h want %h", nm, cap_addr, exp_addr); end
    n_cmp++; if (cap_be !== exp_be) begin n_bad++; $display("FAIL %s be_n: got %b want %b", nm, cap_be, exp_be); end
    n_cmp++; if (cap_doe !== we) begin n_bad++; $display("FAIL %s data_oe: got %b want %b", nm, cap_doe, we); end
    n_cmp++; if (oe_lo != (we ? 0 : RD)) begin n_bad++; $display("FAIL %s oe_n low cycles: got %0d want %0d", nm, oe_lo, we ? 0 : RD); end
    n_cmp++; if (we_lo != (we ? WR : 0)) begin n_bad++; $display("FAIL %s we_n low cycles: got %0d want %0d", nm, we_lo, we ? WR : 0); end
    n_cmp++; if (other_bad) begin n_bad++; $display("FAIL %s idle bank/other ack disturbed: got 1 want 0", nm); end
    if (we) begin
      n_cmp++; if (cap_do !== exp_do) begin n_bad++; $display("FAIL %s data_o: got %h want %h", nm, cap_do, exp_do); end
    end else begin
      n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL %s rdata: got %h want %h", nm, rd, exp_rd); end
    end
    @(posedge clk); #1;
    n_cmp++; if ((if_ack | mem_ack) !== 1'b0) begin n_bad++; $display("FAIL %s ack pulse width: got %b%b want 00", nm, if_ack, mem_ack); end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n} !== 6'b111111) begin
      n_bad++; $display("FAIL reset controls: got %b%b%b%b%b%b want 111111", base_ram_ce_n, base_ram_oe_n,
                        base_ram_we_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n);
    end
    n_cmp++;
    if ({base_ram_be_n, ext_ram_be_n, base_ram_addr, ext_ram_addr} !== {8'hFF, 40'h0}) begin
      n_bad++; $display("FAIL reset be_n/addr: got %h %h %h %h want f f 0 0", base_ram_be_n, ext_ram_be_n, base_ram_addr, ext_ram_addr);
    end
    n_cmp++;
    if ({base_ram_data_o, ext_ram_data_o, base_ram_data_oe, ext_ram_data_oe, if_ack, mem_ack, if_rdata, mem_rdata} !== '0) begin
      n_bad++; $display("FAIL reset data/ack/rdata: got %h %h %b %b %b %b %h %h want all zero", base_ram_data_o,
                        ext_ram_data_o, base_ram_data_oe, ext_ram_data_oe, if_ack, mem_ack, if_rdata, mem_rdata);
    end
    n_cmp++;
    if ({b_base_ce_n, b_ext_ce_n, b_if_ack, b_mem_ack} !== 4'b1100) begin
      n_bad++; $display("FAIL reset swept instance: got %b%b%b%b want 1100", b_base_ce_n, b_ext_ce_n, b_if_ack, b_mem_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_if_read();
    do_access(1, 1, 0, 32'h0000_0010, 32'h1234_5678, "if_prep_write");
    do_access(0, 0, 0, 32'h0000_0010, 32'h0, "if_read");
  endtask

  task automatic test_byte_write();
    do_access(1, 1, 1, 32'h0040_0006, 32'h0000_00AB, "byte_write");
    do_access(1, 0, 0, 32'h0040_0004, 32'h0, "byte_write_readback");
  endtask

  task automatic test_byte_read();
    do_access(1, 1, 0, 32'h0040_0020, 32'h8012_3456, "sign_prep");
    do_access(1, 0, 1, 32'h0040_0023, 32'h0, "byte_read_lane3_neg");
    n_cmp++; if (mem_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL byte_read_lane3 value: got %h want ffffff80", mem_rdata); end
    do_access(1, 1, 0, 32'h0000_0024, 32'h1122_337F, "pos_prep");
    do_access(1, 0, 1, 32'h0000_0024, 32'h0, "byte_read_lane0_pos");
    n_cmp++; if (mem_rdata !== 32'h0000_007F) begin n_bad++; $display("FAIL byte_read_lane0 value: got %h want 0000007f", mem_rdata); end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_byte = 1'b0; mem_addr = 32'h0040_0080; mem_wdata = 32'h5555_AAAA;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (ext_ram_we_n !== 1'b0) begin n_bad++; $display("FAIL mid_write pulse: got we_n=%b want 0", ext_ram_we_n); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ext_ram_we_n, ext_ram_ce_n, ext_ram_data_oe, mem_ack} !== 4'b1100) begin
      n_bad++; $display("FAIL mid_write reset: got we_n,ce_n,oe,ack=%b%b%b%b want 1100", ext_ram_we_n, ext_ram_ce_n, ext_ram_data_oe, mem_ack);
    end
    mem_req = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (mem_ack || if_ack) seen = 1; end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (mem_ack || if_ack) seen = 1; end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_write no ack: got ack=1 want 0"); end
  endtask

  task automatic test_arbitration();
    bit          last_ref = 0;
    bit          exp_mem;
    int          acks = 0, cyc = 0;
    logic [31:0] exp_rd;
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0030;
    mem_req = 1'b1; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = 32'h0040_0044;
    while (acks < 4 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (if_ack || mem_ack) begin
        exp_mem  = !last_ref;
        last_ref = exp_mem;
        exp_rd   = exp_mem ? ref_ext[8'd17] : ref_base[8'd12];
        acks++;
        n_cmp++;
        if ({mem_ack, if_ack} !== {exp_mem, !exp_mem}) begin
          n_bad++; $display("FAIL arb grant %0d: got mem_ack,if_ack=%b%b want %b%b", acks, mem_ack, if_ack, exp_mem, !exp_mem);
        end
        n_cmp++;
        if ((exp_mem ? mem_rdata : if_rdata) !== exp_rd) begin
          n_bad++; $display("FAIL arb rdata %0d: got %h want %h", acks, exp_mem ? mem_rdata : if_rdata, exp_rd);
        end
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    n_cmp++; if (acks != 4) begin n_bad++; $display("FAIL arb ack count: got %0d want 4", acks); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    bit pm, we, byt;
    for (int i = 0; i < 40; i++) begin
      a   = $urandom & 32'h0040_03FF;
      d   = $urandom;
      pm  = 1'($urandom);
      we  = 1'($urandom);
      byt = 1'($urandom);
      do_access(pm, we, byt, a, d, "random");
    end
  endtask

  task automatic test_param_sweep();
    int n, lo;
    bit got;
    @(negedge clk);
    b_if_req = 1'b1; b_if_addr = 32'h0000_0008;
    n = 0; lo = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (!b_base_oe_n) lo++;
      got = b_if_ack;
    end
    b_if_req = 1'b0;
    n_cmp++; if (!got || n != 4) begin n_bad++; $display("FAIL sweep read latency: got %0d want 4", n); end
    n_cmp++; if (lo != 3) begin n_bad++; $display("FAIL sweep oe_n low: got %0d want 3", lo); end
    n_cmp++; if (b_if_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL sweep rdata: got %h want cafef00d", b_if_rdata); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_mem_req = 1'b1; b_mem_we = 1'b1; b_mem_byte = 1'b0; b_mem_addr = 32'h0040_0000; b_mem_wdata = 32'h0BAD_F00D;
    n = 0; lo = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      if (!b_ext_we_n) lo++;
      got = b_mem_ack;
    end
    b_mem_req = 1'b0;
    n_cmp++; if (!got || n != 4) begin n_bad++; $display("FAIL sweep write latency: got %0d want 4", n); end
    n_cmp++; if (lo != 2) begin n_bad++; $display("FAIL sweep we_n low: got %0d want 2", lo); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_byte = 1'b0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_req = 1'b0; b_mem_we = 1'b0; b_mem_byte = 1'b0; b_mem_addr = '0; b_mem_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_base[i] = pat(1'b0, i);
      ref_ext[i]  = pat(1'b1, i);
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_if_read();
    test_byte_write();
    test_byte_read();
    test_reset_mid_write();
    test_arbitration();
    test_random();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
